// File: rtl/adt7310_pkg.sv
// Shared definitions for the ADT7310 measurement responder:
// state encoding, SPI command bytes and the chip-select decode.
package adt7310_pkg;

  localparam int StateWidth = 4;

  localparam logic [StateWidth-1:0] stIdle    = 4'd0;
  localparam logic [StateWidth-1:0] stWrCfg2  = 4'd1;
  localparam logic [StateWidth-1:0] stWaitCfg = 4'd2;
  localparam logic [StateWidth-1:0] stDrain1  = 4'd3;
  localparam logic [StateWidth-1:0] stDrain2  = 4'd4;
  localparam logic [StateWidth-1:0] stWait    = 4'd5;
  localparam logic [StateWidth-1:0] stRdCmd2  = 4'd6;
  localparam logic [StateWidth-1:0] stRdCmd3  = 4'd7;
  localparam logic [StateWidth-1:0] stWaitRd  = 4'd8;
  localparam logic [StateWidth-1:0] stPop0    = 4'd9;
  localparam logic [StateWidth-1:0] stPop1    = 4'd10;
  localparam logic [StateWidth-1:0] stPop2    = 4'd11;
  localparam logic [StateWidth-1:0] stDone    = 4'd12;

  localparam logic [7:0] CmdCfgWrite = 8'h08;
  localparam logic [7:0] CmdOneShot  = 8'h20;
  localparam logic [7:0] CmdTempRead = 8'h50;
  localparam logic [7:0] CmdDummy    = 8'hFF;

  // The sensor is deselected while idle, while it converts, and in the done cycle.
  function automatic logic csInactive(input logic [StateWidth-1:0] state);
    return (state == stIdle) || (state == stWait) || (state == stDone);
  endfunction

endpackage

// File: rtl/adt7310_wait_timer.sv
// Conversion-wait down-counter: loads a preset, counts down while enabled,
// and holds at zero; Zero_o flags the expired count.
module adt7310_wait_timer #(
  parameter int WaitWidth = 32
) (
  input  logic                 Clk_i,
  input  logic                 Reset_i,
  input  logic                 Load_i,
  input  logic [WaitWidth-1:0] Preset_i,
  input  logic                 Enable_i,
  output logic                 Zero_o
);

  logic [WaitWidth-1:0] count;

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      count <= '0;
    end else if (Load_i) begin
      count <= Preset_i;
    end else if (Enable_i && (count != '0)) begin
      count <= count - {{(WaitWidth-1){1'b0}}, 1'b1};
    end
  end

  assign Zero_o = (count == '0);

endmodule

// File: rtl/adt7310_measure.sv
// ADT7310 one-shot measurement responder between the sensor FSM and the SPI master.
// Optional macro ADT7310_MEASURE_FULLCHK_EN: stall every TX write while the SPI TX FIFO is full.
import adt7310_pkg::*;

module adt7310_measure #(
  parameter int DataWidth = 8,
  parameter int WaitWidth = 32
) (
  input  logic                 Clk_i,
  input  logic                 Reset_i,
  input  logic                 Start_i,
  output logic                 Done_o,
  output logic [DataWidth-1:0] Byte0_o,
  output logic [DataWidth-1:0] Byte1_o,
  output logic                 ADT7310CS_n_o,
  output logic                 SPI_Write_o,
  output logic [DataWidth-1:0] SPI_Data_o,
  output logic                 SPI_ReadNext_o,
  input  logic [DataWidth-1:0] SPI_Data_i,
  input  logic                 SPI_FIFOFull_i,
  input  logic                 SPI_FIFOEmpty_i,
  input  logic                 SPI_Transmission_i,
  input  logic [WaitWidth-1:0] ParamWaitPreset_i
);

  logic [StateWidth-1:0] State;
  logic [StateWidth-1:0] NextState;
  logic                  canWrite;
  logic                  timerLoad;
  logic                  timerZero;
  logic                  unusedInputs;

  // Handshake: a byte is pushed into the TX FIFO in every cycle SPI_Write_o is high
  // (write is the valid, canWrite the ready); SPI_ReadNext_o pops the RX head that cycle.
`ifdef ADT7310_MEASURE_FULLCHK_EN
  assign canWrite = !SPI_FIFOFull_i;
`else
  assign canWrite = 1'b1;
`endif

  // RX empty is only observed by the bench; full is unused in the default build.
  assign unusedInputs = &{1'b0, SPI_FIFOEmpty_i, SPI_FIFOFull_i};

  adt7310_wait_timer #(
    .WaitWidth(WaitWidth)
  ) waitTimer (
    .Clk_i    (Clk_i),
    .Reset_i  (Reset_i),
    .Load_i   (timerLoad),
    .Preset_i (ParamWaitPreset_i),
    .Enable_i (State == stWait),
    .Zero_o   (timerZero)
  );

  always_comb begin
    NextState      = State;
    SPI_Write_o    = 1'b0;
    SPI_Data_o     = '0;
    SPI_ReadNext_o = 1'b0;
    timerLoad      = 1'b0;
    case (State)
      stIdle: if (Start_i && canWrite) begin
        SPI_Write_o = 1'b1;
        SPI_Data_o  = DataWidth'(CmdCfgWrite);
        NextState   = stWrCfg2;
      end
      stWrCfg2: if (canWrite) begin
        SPI_Write_o = 1'b1;
        SPI_Data_o  = DataWidth'(CmdOneShot);
        NextState   = stWaitCfg;
      end
      stWaitCfg: if (!SPI_Transmission_i) NextState = stDrain1;
      stDrain1: begin
        SPI_ReadNext_o = 1'b1;
        NextState      = stDrain2;
      end
      stDrain2: begin
        SPI_ReadNext_o = 1'b1;
        timerLoad      = 1'b1;
        NextState      = stWait;
      end
      stWait: if (timerZero && canWrite) begin
        SPI_Write_o = 1'b1;
        SPI_Data_o  = DataWidth'(CmdTempRead);
        NextState   = stRdCmd2;
      end
      stRdCmd2, stRdCmd3: if (canWrite) begin
        SPI_Write_o = 1'b1;
        SPI_Data_o  = DataWidth'(CmdDummy);
        NextState   = (State == stRdCmd2) ? stRdCmd3 : stWaitRd;
      end
      stWaitRd: if (!SPI_Transmission_i) NextState = stPop0;
      stPop0, stPop1, stPop2: begin
        SPI_ReadNext_o = 1'b1;
        NextState      = (State == stPop0) ? stPop1 : ((State == stPop1) ? stPop2 : stDone);
      end
      stDone: NextState = stIdle;
      default: NextState = stIdle;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      State   <= stIdle;
      Byte0_o <= '0;
      Byte1_o <= '0;
    end else begin
      State <= NextState;
      if (State == stPop1) Byte1_o <= SPI_Data_i;
      if (State == stPop2) Byte0_o <= SPI_Data_i;
    end
  end

  assign Done_o        = (State == stDone);
  assign ADT7310CS_n_o = csInactive(State);

endmodule

// File: tb/tb_adt7310_measure.sv
// Bench for adt7310_measure: SPI master / sensor model with configurable shift latency.
`timescale 1ns/1ps
module tb_adt7310_measure;

  logic        Clk_i = 1'b0;
  logic        Reset_i = 1'b1;
  logic        Start_i = 1'b0;
  logic        Done_o;
  logic [7:0]  Byte0_o, Byte1_o;
  logic        ADT7310CS_n_o, SPI_Write_o, SPI_ReadNext_o;
  logic [7:0]  SPI_Data_o, SPI_Data_i;
  logic        SPI_FIFOFull_i = 1'b0;
  logic        SPI_FIFOEmpty_i, SPI_Transmission_i;
  logic [31:0] ParamWaitPreset_i = 32'd0;

  adt7310_measure #(.DataWidth(8), .WaitWidth(32)) dut (
    .Clk_i(Clk_i), .Reset_i(Reset_i), .Start_i(Start_i), .Done_o(Done_o),
    .Byte0_o(Byte0_o), .Byte1_o(Byte1_o), .ADT7310CS_n_o(ADT7310CS_n_o),
    .SPI_Write_o(SPI_Write_o), .SPI_Data_o(SPI_Data_o), .SPI_ReadNext_o(SPI_ReadNext_o),
    .SPI_Data_i(SPI_Data_i), .SPI_FIFOFull_i(SPI_FIFOFull_i), .SPI_FIFOEmpty_i(SPI_FIFOEmpty_i),
    .SPI_Transmission_i(SPI_Transmission_i), .ParamWaitPreset_i(ParamWaitPreset_i)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk_i = ~Clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n_pass=%0d n_checks=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- SPI master + sensor model ----------------
  int          shift_cycles = 0;
  logic        hold_tx = 1'b0;
  logic [7:0]  temp_msb = 8'h00, temp_lsb = 8'h00;
  logic [7:0]  rx_mem [0:63];
  logic [7:0]  pend_mem [0:63];
  logic [15:0] rx_wr = 0, rx_rd = 0, pend_wr = 0, pend_rd = 0;
  int          shift_cnt = 0, ff_seen = 0;
  int          cyc = 0, done_cnt = 0, rn_cnt = 0;
  logic [7:0]  tx_log[$];

  assign SPI_Data_i         = (rx_wr != rx_rd) ? rx_mem[rx_rd[5:0]] : 8'h00;
  assign SPI_FIFOEmpty_i    = (rx_wr == rx_rd);
  assign SPI_Transmission_i = hold_tx | (pend_wr != pend_rd);

  always @(posedge Clk_i) begin
    logic [15:0] nwr, npr, npw;
    int          nsc;
    logic [7:0]  resp;
    cyc <= cyc + 1;
    if (Done_o) done_cnt <= done_cnt + 1;
    if (Reset_i) begin
      rx_wr <= 0; rx_rd <= 0; pend_wr <= 0; pend_rd <= 0; shift_cnt <= 0; ff_seen <= 0;
    end else begin
      nwr = rx_wr; npr = pend_rd; npw = pend_wr; nsc = shift_cnt;
      if (SPI_ReadNext_o) begin
        rn_cnt <= rn_cnt + 1;
        if (rx_rd != rx_wr) rx_rd <= rx_rd + 1;
      end
      if (npw != npr) begin
        if (nsc + 1 >= shift_cycles) begin
          rx_mem[nwr[5:0]] <= pend_mem[npr[5:0]];
          nwr = nwr + 1; npr = npr + 1; nsc = 0;
        end else begin
          nsc = nsc + 1;
        end
      end
      if (SPI_Write_o) begin
        tx_log.push_back(SPI_Data_o);
        // the sensor shifts out the temperature register MSB first on the dummy bytes
        resp = 8'h00;
        if (SPI_Data_o == 8'h50) ff_seen <= 0;
        if (SPI_Data_o == 8'hFF) begin
          resp = (ff_seen == 0) ? temp_msb : temp_lsb;
          ff_seen <= ff_seen + 1;
        end
        if (shift_cycles == 0) begin
          rx_mem[nwr[5:0]] <= resp; nwr = nwr + 1;
        end else begin
          pend_mem[npw[5:0]] <= resp; npw = npw + 1;
        end
      end
      rx_wr <= nwr; pend_rd <= npr; pend_wr <= npw; shift_cnt <= nsc;
    end
  end

  // ---------------- scoreboard state ----------------
  int         n_checks = 0, n_pass = 0;
  logic [7:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic pulse_start(output int c0);
    @(negedge Clk_i);
    Start_i = 1'b1;
    c0 = cyc;
    @(negedge Clk_i);
    Start_i = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit ok, output int at);
    ok = 1'b0; at = 0;
    for (int i = 0; i < max_cycles && !ok; i++) begin
      @(negedge Clk_i);
      if (Done_o) begin ok = 1'b1; at = cyc; end
    end
  endtask

  task automatic wait_read_cmd(input int max_cycles, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      @(negedge Clk_i);
      if (SPI_Write_o && SPI_Data_o == 8'h50) found = 1'b1;
    end
  endtask

  task automatic recover;
    Reset_i = 1'b1; Start_i = 1'b0; SPI_FIFOFull_i = 1'b0; hold_tx = 1'b0;
    repeat (2) @(negedge Clk_i);
    Reset_i = 1'b0;
  endtask

  task automatic check_tx(input string name, input int start_idx);
    exp_q = '{8'h08, 8'h20, 8'h50, 8'hFF, 8'hFF};
    n_checks++;
    if (tx_log.size() - start_idx !== 5) $display("FAIL %s tx_count: got %0d want 5", name, tx_log.size() - start_idx);
    else n_pass++;
    for (int i = 0; i < 5 && start_idx + i < tx_log.size(); i++) begin
      n_checks++;
      if (tx_log[start_idx + i] !== exp_q[i]) $display("FAIL %s tx[%0d]: got %h want %h", name, i, tx_log[start_idx + i], exp_q[i]);
      else n_pass++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int c0, d0;
    Reset_i = 1'b1;
    repeat (3) @(negedge Clk_i);
    Reset_i = 1'b0;
    n_checks++; if (ADT7310CS_n_o !== 1'b1) $display("FAIL reset cs_n: got %b want 1", ADT7310CS_n_o); else n_pass++;
    n_checks++; if (SPI_Write_o !== 1'b0) $display("FAIL reset write: got %b want 0", SPI_Write_o); else n_pass++;
    n_checks++; if (SPI_ReadNext_o !== 1'b0) $display("FAIL reset readnext: got %b want 0", SPI_ReadNext_o); else n_pass++;
    n_checks++; if (SPI_Data_o !== 8'h00) $display("FAIL reset data: got %h want 00", SPI_Data_o); else n_pass++;
    n_checks++; if (Done_o !== 1'b0) $display("FAIL reset done: got %b want 0", Done_o); else n_pass++;
    n_checks++; if ({Byte1_o, Byte0_o} !== 16'h0000) $display("FAIL reset bytes: got %h want 0000", {Byte1_o, Byte0_o}); else n_pass++;
    // interrupt a transaction while the sensor is converting
    shift_cycles = 0; ParamWaitPreset_i = 32'd50; temp_msb = 8'hA5; temp_lsb = 8'h5A;
    d0 = done_cnt;
    pulse_start(c0);
    repeat (8) @(negedge Clk_i);
    n_checks++; if (ADT7310CS_n_o !== 1'b1) $display("FAIL midwait cs_n: got %b want 1", ADT7310CS_n_o); else n_pass++;
    Reset_i = 1'b1;
    repeat (3) @(negedge Clk_i);
    n_checks++; if ({ADT7310CS_n_o, SPI_Write_o, SPI_ReadNext_o} !== 3'b100) $display("FAIL midwait reset outputs: got %b want 100", {ADT7310CS_n_o, SPI_Write_o, SPI_ReadNext_o}); else n_pass++;
    Reset_i = 1'b0;
    repeat (80) @(negedge Clk_i);
    n_checks++; if (done_cnt - d0 !== 0) $display("FAIL midwait done pulses: got %0d want 0", done_cnt - d0); else n_pass++;
    n_checks++; if ({Byte1_o, Byte0_o} !== 16'h0000) $display("FAIL midwait bytes: got %h want 0000", {Byte1_o, Byte0_o}); else n_pass++;
  endtask

  task automatic test_measure(input int iters);
    int c0, cd, s, r0, d0, p;
    bit ok;
    for (int it = 0; it < iters; it++) begin
      if (it == 0) begin
        p = 4; shift_cycles = 0; temp_msb = 8'h1A; temp_lsb = 8'h3C;
      end else if (it == 1) begin
        p = 0; shift_cycles = 0; temp_msb = $urandom; temp_lsb = $urandom;
      end else begin
        p = $urandom_range(0, 12); shift_cycles = $urandom_range(0, 3);
        temp_msb = $urandom; temp_lsb = $urandom;
      end
      ParamWaitPreset_i = p;
      s = tx_log.size(); r0 = rn_cnt; d0 = done_cnt;
      pulse_start(c0);
      wait_done(200, ok, cd);
      n_checks++; if (ok !== 1'b1) $display("FAIL measure%0d done timeout: got %b want 1", it, ok); else n_pass++;
      n_checks++; if (Byte1_o !== temp_msb) $display("FAIL measure%0d byte1: got %h want %h", it, Byte1_o, temp_msb); else n_pass++;
      n_checks++; if (Byte0_o !== temp_lsb) $display("FAIL measure%0d byte0: got %h want %h", it, Byte0_o, temp_lsb); else n_pass++;
      n_checks++; if (ADT7310CS_n_o !== 1'b1) $display("FAIL measure%0d cs_n at done: got %b want 1", it, ADT7310CS_n_o); else n_pass++;
      if (shift_cycles == 0) begin
        n_checks++; if (cd - c0 + 1 !== 13 + p) $display("FAIL measure%0d latency: got %0d want %0d", it, cd - c0 + 1, 13 + p); else n_pass++;
      end else begin
        n_checks++; if ((cd - c0 + 1 >= 13 + p) !== 1'b1) $display("FAIL measure%0d latency: got %0d want >=%0d", it, cd - c0 + 1, 13 + p); else n_pass++;
      end
      @(negedge Clk_i);
      n_checks++; if (Done_o !== 1'b0) $display("FAIL measure%0d done width: got %b want 0", it, Done_o); else n_pass++;
      n_checks++; if (done_cnt - d0 !== 1) $display("FAIL measure%0d done pulses: got %0d want 1", it, done_cnt - d0); else n_pass++;
      n_checks++; if (rn_cnt - r0 !== 5) $display("FAIL measure%0d readnext: got %0d want 5", it, rn_cnt - r0); else n_pass++;
      check_tx($sformatf("measure%0d", it), s);
      if (!ok) recover();
      repeat ($urandom_range(0, 3)) @(negedge Clk_i);
    end
  endtask

  task automatic test_back_to_back;
    int s, d0, cd;
    bit ok;
    shift_cycles = 1; ParamWaitPreset_i = $urandom_range(0, 6);
    temp_msb = $urandom; temp_lsb = $urandom;
    s = tx_log.size(); d0 = done_cnt;
    @(negedge Clk_i);
    Start_i = 1'b1;
    wait_done(200, ok, cd);
    n_checks++; if (ok !== 1'b1) $display("FAIL b2b first done timeout: got %b want 1", ok); else n_pass++;
    n_checks++; if ({Byte1_o, Byte0_o} !== {temp_msb, temp_lsb}) $display("FAIL b2b first bytes: got %h want %h", {Byte1_o, Byte0_o}, {temp_msb, temp_lsb}); else n_pass++;
    n_checks++; if (tx_log.size() - s !== 5) $display("FAIL b2b writes per visit: got %0d want 5", tx_log.size() - s); else n_pass++;
    temp_msb = $urandom; temp_lsb = $urandom;
    @(negedge Clk_i);
    n_checks++; if ({SPI_Write_o, SPI_Data_o} !== {1'b1, 8'h08}) $display("FAIL b2b restart write: got %b/%h want 1/08", SPI_Write_o, SPI_Data_o); else n_pass++;
    @(negedge Clk_i);
    Start_i = 1'b0;
    wait_done(200, ok, cd);
    n_checks++; if (ok !== 1'b1) $display("FAIL b2b second done timeout: got %b want 1", ok); else n_pass++;
    n_checks++; if ({Byte1_o, Byte0_o} !== {temp_msb, temp_lsb}) $display("FAIL b2b second bytes: got %h want %h", {Byte1_o, Byte0_o}, {temp_msb, temp_lsb}); else n_pass++;
    repeat (20) @(negedge Clk_i);
    n_checks++; if (done_cnt - d0 !== 2) $display("FAIL b2b done pulses: got %0d want 2", done_cnt - d0); else n_pass++;
    n_checks++; if (tx_log.size() - s !== 10) $display("FAIL b2b total writes: got %0d want 10", tx_log.size() - s); else n_pass++;
    check_tx("b2b_second", s + 5);
    if (!ok) recover();
  endtask

  task automatic test_fifo_full;
    int c0, cd, s, s2, cs_hi, exp_w;
    bit ok, found;
    shift_cycles = 2; ParamWaitPreset_i = $urandom_range(0, 5);
    temp_msb = $urandom; temp_lsb = $urandom;
    s = tx_log.size();
    pulse_start(c0);
    wait_read_cmd(100, found);
    n_checks++; if (found !== 1'b1) $display("FAIL full read cmd seen: got %b want 1", found); else n_pass++;
    @(negedge Clk_i);
    SPI_FIFOFull_i = 1'b1;
    s2 = tx_log.size(); cs_hi = 0;
    repeat (5) begin
      @(negedge Clk_i);
      if (ADT7310CS_n_o) cs_hi++;
    end
    SPI_FIFOFull_i = 1'b0;
`ifdef ADT7310_MEASURE_FULLCHK_EN
    exp_w = 0;
`else
    exp_w = 2;
`endif
    n_checks++; if (tx_log.size() - s2 !== exp_w) $display("FAIL full writes during stall: got %0d want %0d", tx_log.size() - s2, exp_w); else n_pass++;
    n_checks++; if (cs_hi !== 0) $display("FAIL full cs_n high cycles: got %0d want 0", cs_hi); else n_pass++;
    wait_done(200, ok, cd);
    n_checks++; if (ok !== 1'b1) $display("FAIL full done timeout: got %b want 1", ok); else n_pass++;
    n_checks++; if ({Byte1_o, Byte0_o} !== {temp_msb, temp_lsb}) $display("FAIL full bytes: got %h want %h", {Byte1_o, Byte0_o}, {temp_msb, temp_lsb}); else n_pass++;
    check_tx("full", s);
    if (!ok) recover();
  endtask

  task automatic test_tx_hold;
    int c0, cd, r0, d0, cs_hi;
    bit ok, found;
    shift_cycles = 1; ParamWaitPreset_i = $urandom_range(0, 5);
    temp_msb = $urandom; temp_lsb = $urandom;
    pulse_start(c0);
    wait_read_cmd(100, found);
    n_checks++; if (found !== 1'b1) $display("FAIL hold read cmd seen: got %b want 1", found); else n_pass++;
    hold_tx = 1'b1;
    r0 = rn_cnt; d0 = done_cnt; cs_hi = 0;
    repeat (100) begin
      @(negedge Clk_i);
      if (ADT7310CS_n_o) cs_hi++;
    end
    n_checks++; if (rn_cnt - r0 !== 0) $display("FAIL hold pops while busy: got %0d want 0", rn_cnt - r0); else n_pass++;
    n_checks++; if (cs_hi !== 0) $display("FAIL hold cs_n high cycles: got %0d want 0", cs_hi); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 0) $display("FAIL hold early done: got %0d want 0", done_cnt - d0); else n_pass++;
    hold_tx = 1'b0;
    wait_done(50, ok, cd);
    n_checks++; if (ok !== 1'b1) $display("FAIL hold done timeout: got %b want 1", ok); else n_pass++;
    n_checks++; if ({Byte1_o, Byte0_o} !== {temp_msb, temp_lsb}) $display("FAIL hold bytes: got %h want %h", {Byte1_o, Byte0_o}, {temp_msb, temp_lsb}); else n_pass++;
    n_checks++; if (rn_cnt - r0 !== 3) $display("FAIL hold pops after release: got %0d want 3", rn_cnt - r0); else n_pass++;
    if (!ok) recover();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_measure(10);
    test_back_to_back();
    test_fifo_full();
    test_tx_hold();
    repeat (3) @(negedge Clk_i);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adt7310_measure.md
# adt7310_measure

Measurement responder for the ADT7310 SPI temperature sensor: on a one-cycle start request from the sensor FSM it triggers a one-shot conversion, waits a programmable conversion time, reads the 16-bit temperature register and returns both bytes with a one-cycle done pulse. It sits between the sensor FSM (start/done/byte handshake) and the shared byte-wide SPI master (TX/RX FIFOs, transmission flag), and owns the sensor chip-select.

## Interface
- DataWidth, 8, SPI byte width; Byte0_o/Byte1_o width
- WaitWidth, 32, conversion-wait counter width
- Clk_i  in  1  system clock; all logic on rising edge
- Reset_i  in  1  synchronous, active-high reset
- Start_i  in  1  start request; sampled only in stIdle
- Done_o  out  1  one-cycle pulse, bytes valid
- Byte0_o  out  DataWidth  temperature LSB (second byte received)
- Byte1_o  out  DataWidth  temperature MSB (first byte received)
- ADT7310CS_n_o  out  1  sensor chip select, active low
- SPI_Write_o  out  1  push SPI_Data_o into SPI TX FIFO
- SPI_Data_o  out  DataWidth  TX byte
- SPI_ReadNext_o  out  1  pop RX FIFO head
- SPI_Data_i  in  DataWidth  RX FIFO head
- SPI_FIFOFull_i  in  1  TX FIFO full
- SPI_FIFOEmpty_i  in  1  RX FIFO empty (bench observation only)
- SPI_Transmission_i  in  1  SPI master shifting
- ParamWaitPreset_i  in  WaitWidth  conversion wait, in cycles minus one

## Operation
- States: stIdle, stWrCfg2, stWaitCfg, stDrain1, stDrain2, stWait, stRdCmd2, stRdCmd3, stWaitRd, stPop0, stPop1, stPop2, stDone.
- stIdle: Start_i=1 -> SPI_Write_o=1, SPI_Data_o=0x08 (write config register) -> stWrCfg2.
- stWrCfg2: write 0x20 (one-shot mode) -> stWaitCfg.
- stWaitCfg: SPI_Transmission_i=0 -> stDrain1.
- stDrain1/stDrain2: SPI_ReadNext_o=1 each (discard 2 echo bytes); stDrain2 loads timer with ParamWaitPreset_i -> stWait.
- stWait: timer decrements; timer==0 -> write 0x50 (read temperature) -> stRdCmd2.
- stRdCmd2, stRdCmd3: write 0xFF each -> stWaitRd.
- stWaitRd: SPI_Transmission_i=0 -> stPop0.
- stPop0: ReadNext (discard command echo). stPop1: Byte1_o<=SPI_Data_i, ReadNext. stPop2: Byte0_o<=SPI_Data_i, ReadNext.
- stDone: Done_o=1 -> stIdle.
- ADT7310CS_n_o decoded from state: 1 in stIdle, stWait, stDone; 0 otherwise.
- Byte0_o/Byte1_o hold until overwritten; not cleared at start.
- Start_i outside stIdle ignored; no queueing.

## Timing
- Reset: state stIdle, timer 0, Byte0_o=Byte1_o=0, Done_o=0, ADT7310CS_n_o=1, SPI_Write_o=SPI_ReadNext_o=0, SPI_Data_o=0.
- SPI_Write_o/SPI_Data_o/SPI_ReadNext_o combinational from state (and Start_i in stIdle); first write in the Start_i cycle.
- SPI master raises SPI_Transmission_i within one cycle of first write; wait states are entered ≥2 cycles after the first write of their group, so flag is already high.
- stWait occupies ParamWaitPreset_i+1 cycles; preset 0 -> one cycle.
- Done_o one cycle after stPop2; Byte0_o/Byte1_o valid in that cycle.
- Minimum Start->Done with instantaneous SPI: 13 + ParamWaitPreset_i cycles.
- Reset_i mid-transaction: next edge to stIdle, CS high; RX FIFO residue is the SPI master's responsibility (reset shared).

## Configuration
- ADT7310_MEASURE_FULLCHK_EN defined: every write state (stIdle with Start_i, stWrCfg2, stRdCmd2, stRdCmd3, stWait exit) suppresses SPI_Write_o and stays put while SPI_FIFOFull_i=1; timer stays 0 in stWait during the stall.
- Undefined: writes unconditional, SPI_FIFOFull_i unused.

## Structure
- Package adt7310_pkg: state encoding localparams, command bytes (0x08 CfgWrite, 0x20 OneShot, 0x50 TempRead, 0xFF Dummy).
- Sub-module adt7310_wait_timer: WaitWidth down-counter with load, enable, zero flag.

## Test plan
- Reset_i held 3 cycles mid-stWait -> stIdle, CS_n=1, Done_o never pulses, bytes 0.
- Start_i pulse, preset 4, SPI model returns 0x00,0x00,0x00,0x1A,0x3C -> Done_o single pulse, Byte1_o=0x1A, Byte0_o=0x3C; TX sequence 0x08,0x20,0x50,0xFF,0xFF; exactly 5 ReadNext pulses.
- Preset 0 -> stWait one cycle; Start->Done = 13 cycles with zero-latency SPI model.
- Start_i held high through whole transaction -> exactly one transaction per stIdle visit; back-to-back transaction begins the cycle after Done_o.
- With ADT7310_MEASURE_FULLCHK_EN, SPI_FIFOFull_i=1 for 5 cycles at stRdCmd2 -> no write, state held, 0xFF written on release; without macro -> write proceeds.
- SPI_Transmission_i held high 100 cycles in stWaitRd -> no pops, CS_n stays 0, Done_o after release.
